// File: rtl/sram_mem_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as two
// half-word accesses (low then high), each held for WAIT_CYCLES cycles; ~ready freezes the pipeline.
module sram_mem_controller #(
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        data_q;
  logic               op_write;
  logic [15:0]        low_half;
  logic               req;
  logic               last;

  assign req  = rd_en | wr_en;
  assign last = (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req)  state_next = LOW;
      LOW:     if (last) state_next = HIGH;
      HIGH:    if (last) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Wait counter, access latch and read assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      word_q    <= '0;
      data_q    <= '0;
      op_write  <= 1'b0;
      low_half  <= '0;
      read_data <= '0;
    end else begin
      if (state == IDLE && req) begin
        cnt      <= CNT_LOAD;
        word_q   <= (SRAM_AW-1)'((address - 32'(BASE_ADDR)) >> 2);
        data_q   <= write_data;
        op_write <= wr_en;
      end else if (state == LOW && last) begin
        cnt <= CNT_LOAD;
      end else if (!last) begin
        cnt <= cnt - 1'b1;
      end

      if (!op_write && last) begin
        if (state == LOW)  low_half  <= sram_dq_in;
        if (state == HIGH) read_data <= {sram_dq_in, low_half};
      end
    end
  end

  // Outputs; the final cycle of each half keeps we_n high for address/data hold
  // unless there is only one cycle to give.
  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    unique case (state)
      IDLE: ready = rst || !req;
      LOW: begin
        sram_addr = {word_q, 1'b0};
        if (op_write) begin
          sram_dq_out = data_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = last && (WAIT_CYCLES > 1);
        end
      end
      HIGH: begin
        sram_addr = {word_q, 1'b1};
        if (op_write) begin
          sram_dq_out = data_q[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = last && (WAIT_CYCLES > 1);
        end
      end
      default: ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller (WAIT_CYCLES=2) with a small behavioural SRAM
// model; every expectation is a hand-computed constant.
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  int passed = 0;
  int total  = 0;

  logic [15:0] mem [0:63];
  logic        mem_clr = 1'b1;

  always #5 clk = ~clk;

  sram_mem_controller dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n)
  );

  // SRAM model: a write lands on any edge with we_n low and the bus driven.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
    end else if (!sram_we_n && sram_dq_oe) begin
      mem[sram_addr[5:0]] <= sram_dq_out;
    end
  end
  assign sram_dq_in = mem[sram_addr[5:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_check(input string tag, input logic [31:0] a, input logic [31:0] dq,
                           input logic we_n, input logic oe);
    check({tag, " sram_addr"}, 32'(sram_addr), a);
    check({tag, " dq_out"}, 32'(sram_dq_out), dq);
    check({tag, " we_n"}, 32'(sram_we_n), 32'(we_n));
    check({tag, " oe"}, 32'(sram_dq_oe), 32'(oe));
  endtask

  // Called just after a rising edge; returns at the falling edge of the DONE cycle.
  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int n;
    n = 0;
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    @(negedge clk);
    check({tag, " accept ready"}, 32'(ready), 32'd0);
    while (!ready && n < 20) begin
      next_cycle();
      rd_en = 1'b0; wr_en = 1'b0;
      n++;
      @(negedge clk);
    end
    check({tag, " done cycle"}, 32'(n), 32'd5);
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b1; wr_en = 1'b0;
    address = 32'd1028; write_data = 32'h0;

    // Reset held two cycles with a read request pending.
    next_cycle();
    mem_clr = 1'b0;
    @(negedge clk);
    bus_check("reset1", 32'd0, 32'd0, 1'b1, 1'b0);
    check("reset1 read_data", read_data, 32'd0);
    check("reset1 ready", 32'(ready), 32'd1);
    next_cycle();
    @(negedge clk);
    check("reset2 we_n", 32'(sram_we_n), 32'd1);
    check("reset2 ready", 32'(ready), 32'd1);
    next_cycle();
    rst = 1'b0;
    access(1'b0, 1'b1, 32'd1028, 32'd0, "post_reset_read");
    check("post_reset_read data", read_data, 32'd0);

    // Write 0xDEADBEEF to 1028, cycle by cycle.
    next_cycle();
    wr_en = 1'b1; address = 32'd1028; write_data = 32'hDEADBEEF;
    @(negedge clk);
    check("wr c0 ready", 32'(ready), 32'd0);
    next_cycle(); wr_en = 1'b0; address = 32'd0; write_data = 32'h0;
    @(negedge clk); bus_check("wr c1", 32'd2, 32'h0000BEEF, 1'b0, 1'b1);
    next_cycle();
    @(negedge clk); bus_check("wr c2", 32'd2, 32'h0000BEEF, 1'b1, 1'b1);
    check("wr c2 ready", 32'(ready), 32'd0);
    next_cycle();
    @(negedge clk); bus_check("wr c3", 32'd3, 32'h0000DEAD, 1'b0, 1'b1);
    next_cycle();
    @(negedge clk); bus_check("wr c4", 32'd3, 32'h0000DEAD, 1'b1, 1'b1);
    next_cycle();
    @(negedge clk);
    check("wr c5 ready", 32'(ready), 32'd1);
    bus_check("wr c5", 32'd0, 32'd0, 1'b1, 1'b0);
    check("wr mem lo", 32'(mem[2]), 32'h0000BEEF);
    check("wr mem hi", 32'(mem[3]), 32'h0000DEAD);

    // Read it back.
    next_cycle();
    access(1'b0, 1'b1, 32'd1028, 32'd0, "rd1028");
    check("rd1028 data", read_data, 32'hDEADBEEF);

    // Back-to-back write then read of 1024.
    next_cycle();
    access(1'b1, 1'b0, 32'd1024, 32'h00000011, "b2b_wr");
    check("b2b_wr read_data held", read_data, 32'hDEADBEEF);
    next_cycle();
    access(1'b0, 1'b1, 32'd1024, 32'd0, "b2b_rd");
    check("b2b_rd data", read_data, 32'h00000011);

    // Both enables: write wins.
    next_cycle();
    access(1'b1, 1'b1, 32'd1032, 32'h12345678, "both");
    check("both read_data held", read_data, 32'h00000011);
    check("both mem lo", 32'(mem[4]), 32'h00005678);
    check("both mem hi", 32'(mem[5]), 32'h00001234);

    // Reset during cycle 2 of a write to 1040 (SRAM words 8/9).
    next_cycle();
    wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
    @(negedge clk);
    next_cycle(); wr_en = 1'b0;
    @(negedge clk); bus_check("rstmid c1", 32'd8, 32'h0000F00D, 1'b0, 1'b1);
    next_cycle(); rst = 1'b1;
    @(negedge clk);
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    check("rstmid c3 ready", 32'(ready), 32'd1);
    bus_check("rstmid c3", 32'd0, 32'd0, 1'b1, 1'b0);
    check("rstmid read_data", read_data, 32'd0);
    next_cycle(); next_cycle(); next_cycle();
    @(negedge clk);
    check("rstmid mem lo", 32'(mem[8]), 32'h0000F00D);
    check("rstmid mem hi", 32'(mem[9]), 32'h00000000);
    check("rstmid idle ready", 32'(ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_mem_controller.md
# sram_mem_controller

Multi-cycle controller that sequences 32-bit data-memory accesses from the pipeline's MEM stage onto an external 16-bit-wide, single-port asynchronous SRAM. It splits each word access into two half-word accesses, low half then high half, and holds each half for a programmable number of wait cycles. While an access is in flight it deasserts `ready`; the top level uses `~ready` as the pipeline freeze for every stage register.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: cycles each half-word access is held; legal range ≥ 1.
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.
- `SRAM_AW`, default 18: SRAM half-word address width.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rd_en` in 1: MEM-stage read request.
- `wr_en` in 1: MEM-stage write request.
- `address` in 32: byte address from the ALU result.
- `write_data` in 32: store data (Rm value).
- `read_data` out 32: registered load result.
- `ready` out 1: high when no access is pending or the access completes this cycle.
- `sram_addr` out SRAM_AW: half-word address to the SRAM.
- `sram_dq_out` out 16: write data to the SRAM.
- `sram_dq_oe` out 1: data-bus output enable for the pad driver.
- `sram_dq_in` in 16: read data from the SRAM.
- `sram_we_n` out 1: SRAM write strobe, active-low.

## Operation
- Word index: `w = (address - BASE_ADDR) >> 2`, truncated to SRAM_AW-1 bits. No range check is performed.
- Low half-word lives at SRAM address `{w,0}`; high half-word at `{w,1}`.
- States:
  - IDLE: if `wr_en|rd_en`, latch the address, `write_data`, and op (write wins if both are asserted), then go to LOW.
  - LOW: hold for WAIT_CYCLES cycles, then go to HIGH.
  - HIGH: hold for WAIT_CYCLES cycles, then go to DONE.
  - DONE: one cycle, then go to IDLE.
- A down-counter is loaded with WAIT_CYCLES-1 on entry to LOW and to HIGH. It decrements each cycle, and the state advances when it reaches 0.
- `ready` is combinational:
  - 1 in IDLE with no request.
  - 0 in IDLE with a request, and throughout LOW and HIGH.
  - 1 in DONE.
- LOW drives `sram_addr={w,0}`. HIGH drives `sram_addr={w,1}`. IDLE and DONE drive 0.
- Write op:
  - `sram_dq_oe=1` in LOW and HIGH.
  - `sram_dq_out` = latched data [15:0] in LOW, [31:16] in HIGH.
  - `sram_we_n=0` on every cycle of LOW and HIGH except the last cycle of each, which provides address/data hold.
  - With WAIT_CYCLES=1, `sram_we_n` stays 0 for that single cycle.
- Read op:
  - `sram_we_n=1` and `sram_dq_oe=0` throughout.
  - On the edge ending the last LOW cycle, capture `sram_dq_in` into a low-half holding register.
  - On the edge ending the last HIGH cycle, write `read_data <= {sram_dq_in, low_half}`.
- `read_data` is unchanged by writes and holds its value until the next read completes.
- Requests are sampled only in IDLE. Deasserting or changing `rd_en`/`wr_en`/`address` mid-access has no effect; the latched access completes.

## Timing
- Reset values: state IDLE, `read_data=0`, `sram_addr=0`, `sram_dq_out=0`, `sram_dq_oe=0`, `sram_we_n=1`, `ready=1` (no request).
- Request seen in cycle 0:
  - `ready` is low in cycles 0 … 2·WAIT_CYCLES.
  - `ready` is high in cycle 2·WAIT_CYCLES+1 (DONE).
  - Freeze length is therefore 2·WAIT_CYCLES+1 cycles.
- In DONE, `read_data` already holds the new load value. The pipeline advances on the edge ending DONE.
- If a new request is present in the cycle after DONE, it is accepted in IDLE with `ready=0`. There are no idle bubbles between back-to-back accesses beyond DONE.
- Reset asserted in any state:
  - Next cycle is IDLE with all reset values, including `read_data=0`.
  - The in-flight write is abandoned, and `sram_we_n` returns to 1 at that edge.

## Test plan
- Reset: hold `rst` 2 cycles with `rd_en=1`. Required: `sram_we_n=1`, `read_data=0`, `sram_dq_oe=0`; `ready=0` only after `rst` falls.
- Write, WAIT_CYCLES=2: `wr_en`, address 1028, data 0xDEADBEEF.
  - Cycles 1–2: `sram_addr=2`, `sram_dq_out=0xBEEF`, `we_n` = 0 then 1.
  - Cycles 3–4: `sram_addr=3`, `sram_dq_out=0xDEAD`, `we_n` = 0 then 1.
  - Cycle 5: `ready=1`.
- Read back from an SRAM model: `rd_en`, address 1028. Required: `read_data=0xDEADBEEF` and `ready=1` in cycle 5; `read_data` is unchanged by a following write.
- Back-to-back: write 0x00000011 to 1024, immediately followed by a read of 1024. Required: second access starts in the cycle after DONE; read returns 0x00000011; `ready` is high for exactly one cycle between the two accesses.
- Both `rd_en` and `wr_en` asserted, address 1032, data 0x12345678. Required: treated as a write to SRAM addresses 4 and 5; `read_data` is unchanged.
- Reset mid-write: assert `rst` in cycle 2 of a write. Required: `sram_we_n=1`, state IDLE, `ready=1` in cycle 3; the SRAM model's high half is not written.
